hazard_ctrl_unit: RTL

- Parametrised successor to the split forwarding and hazard-detection logic of the 5-stage RISC-V pipeline. Merges forwarding, load-use stalls, branch flush and multi-cycle-op stalls into one sequential controller.
- Sits beside the ifetch, idecode and ixecute stages. Drives their write-enable, flush and stall controls and the E-stage operand muxes.
- Supports a configurable data-memory load latency and a variable-latency execute unit (mul/div) through a start/done handshake.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_ctrl_unit_if.sv | 38 +++
 rtl/hazard_ctrl_unit_fwd_select.sv | 25 ++
 rtl/hazard_ctrl_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and forwarding selects.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MCWAIT = 2'd2
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of pipeline-side hazard inputs and controller outputs.
// master: the pipeline stages; slave: the hazard controller.
interface hazard_ctrl_unit_if #(
    parameter int unsigned REG_AW = 5
);
    import hazard_pkg::*;

    logic [REG_AW-1:0] Rs1D, Rs2D;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic [REG_AW-1:0] RdM, RdW;
    logic              MemReadE;
    logic              RegWriteM, RegWriteW;
    logic              PCSrcE;
    logic              McStartE;
    logic              McDone;

    logic              PCWrite, IF_IDWrite;
    logic              FlushD, FlushE;
    logic              StallE;
    logic              FlushM;
    fwd_sel_t          ForwardA, ForwardB;
    logic              Busy;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output MemReadE, RegWriteM, RegWriteW, PCSrcE, McStartE, McDone,
        input  PCWrite, IF_IDWrite, FlushD, FlushE, StallE, FlushM,
        input  ForwardA, ForwardB, Busy
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  MemReadE, RegWriteM, RegWriteW, PCSrcE, McStartE, McDone,
        output PCWrite, IF_IDWrite, FlushD, FlushE, StallE, FlushM,
        output ForwardA, ForwardB, Busy
    );

endinterface

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Per-operand forwarding comparator. M stage wins over W; x0 never forwards.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              reg_write_m_i,
    input  logic              reg_write_w_i,
    output fwd_sel_t          fwd_o
);

    // Priority select of the youngest in-flight producer
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Unified hazard controller: forwarding, load-use stalls, branch flush and
// multi-cycle-op stalls. Optional perf counters under macro HAZ_PERF_CNT_EN.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_unit_if.slave hz_if
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] LuseStallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] McStallCnt
`endif
);

    localparam logic [REG_AW-1:0] RegZero = '0;
    // First bubble is spent in RUN, so LSTALL covers the remaining LOAD_LAT-1
    localparam logic [2:0]        LoadCnt = 3'(LOAD_LAT - 1);

    hz_state_t  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       luse;
    logic       pc_write, if_id_write, flush_d, flush_e, stall_e, flush_m;
    logic       luse_cyc, flush_cyc;
    fwd_sel_t   fwd_a, fwd_b;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_e_i        (hz_if.Rs1E),
        .rd_m_i        (hz_if.RdM),
        .rd_w_i        (hz_if.RdW),
        .reg_write_m_i (hz_if.RegWriteM),
        .reg_write_w_i (hz_if.RegWriteW),
        .fwd_o         (fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_e_i        (hz_if.Rs2E),
        .rd_m_i        (hz_if.RdM),
        .rd_w_i        (hz_if.RdW),
        .reg_write_m_i (hz_if.RegWriteM),
        .reg_write_w_i (hz_if.RegWriteW),
        .fwd_o         (fwd_b)
    );

    assign luse = hz_if.MemReadE && (hz_if.RdE != RegZero) &&
                  ((hz_if.RdE == hz_if.Rs1D) || (hz_if.RdE == hz_if.Rs2D));

    // Next-state and same-cycle pipeline controls
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        stall_e     = 1'b0;
        flush_m     = 1'b0;
        luse_cyc    = 1'b0;
        flush_cyc   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (hz_if.PCSrcE) begin
                    flush_d   = 1'b1;
                    flush_e   = 1'b1;
                    flush_cyc = 1'b1;
                end else if (hz_if.McStartE) begin
                    // A zero-latency unit finishes in the start cycle: no stall at all
                    if (!hz_if.McDone) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        stall_e     = 1'b1;
                        flush_m     = 1'b1;
                        state_d     = MCWAIT;
                    end
                end else if (luse) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    flush_e     = 1'b1;
                    luse_cyc    = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = LSTALL;
                        cnt_d   = LoadCnt;
                    end
                end
            end
            LSTALL: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                flush_e     = 1'b1;
                luse_cyc    = 1'b1;
                cnt_d       = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RUN;
                end
            end
            MCWAIT: begin
                if (hz_if.McDone) begin
                    state_d = RUN;
                end else begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    stall_e     = 1'b1;
                    flush_m     = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State register; reset aborts any stall straight back to RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs forced to their idle values while reset is held
    always_comb begin
        hz_if.PCWrite    = 1'b1;
        hz_if.IF_IDWrite = 1'b1;
        hz_if.FlushD     = 1'b0;
        hz_if.FlushE     = 1'b0;
        hz_if.StallE     = 1'b0;
        hz_if.FlushM     = 1'b0;
        hz_if.ForwardA   = FWD_RF;
        hz_if.ForwardB   = FWD_RF;
        hz_if.Busy       = 1'b0;
        if (reset) begin
            hz_if.PCWrite    = pc_write;
            hz_if.IF_IDWrite = if_id_write;
            hz_if.FlushD     = flush_d;
            hz_if.FlushE     = flush_e;
            hz_if.StallE     = stall_e;
            hz_if.FlushM     = flush_m;
            hz_if.ForwardA   = fwd_a;
            hz_if.ForwardB   = fwd_b;
            hz_if.Busy       = (state_q != RUN);
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] luse_cnt_q, flush_cnt_q, mc_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            luse_cnt_q  <= '0;
            flush_cnt_q <= '0;
            mc_cnt_q    <= '0;
        end else begin
            if (luse_cyc && (luse_cnt_q != '1)) begin
                luse_cnt_q <= luse_cnt_q + 1'b1;
            end
            if (flush_cyc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            if ((state_q == MCWAIT) && (mc_cnt_q != '1)) begin
                mc_cnt_q <= mc_cnt_q + 1'b1;
            end
        end
    end

    assign LuseStallCnt = luse_cnt_q;
    assign FlushCnt     = flush_cnt_q;
    assign McStallCnt   = mc_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = ^{luse_cyc, flush_cyc};
`endif

endmodule
